branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl_pkg.sv | 18 +
 rtl/branch_cond.sv | 37 +++
 rtl/branch_ctrl.sv | 135 +++++++++++++
 tb/tb_branch_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch resolution block: funct3 encodings and
// the controller state type.
package branch_ctrl_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation: all compare flags come from a single 33-bit
// subtraction, then funct3 picks one of them.
module branch_cond
    import branch_ctrl_pkg::*;
(
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  funct3,
    output logic        cond
);

    logic [32:0] diff;
    logic        eq;
    logic        lt;
    logic        ltu;

    assign diff = {1'b0, rs1} - {1'b0, rs2};
    assign eq   = (diff[31:0] == 32'd0);
    // Bit 32 is the borrow of the zero-extended subtraction.
    assign ltu  = diff[32];
    // Signed: differing signs decide directly, otherwise the difference sign.
    assign lt   = (rs1[31] != rs2[31]) ? rs1[31] : diff[31];

    always_comb begin
        cond = eq;
        case (funct3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = !eq;
            F3_BLT:  cond = lt;
            F3_BGE:  cond = !lt;
            F3_BLTU: cond = ltu;
            F3_BGEU: cond = !ltu;
            default: cond = eq;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: latches a request, resolves it one cycle
// later and, for an aligned taken branch, holds a redirect until fetch takes it.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [31:0]      req_pc,
    input  logic [31:0]      req_imm,
    input  logic             kill,
    output logic             res_valid,
    output logic             res_taken,
    output logic             misalign,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    input  logic             redir_ready,
    output logic             flush,
    output logic [CNT_W-1:0] taken_cnt,
    output state_t           dbg_state
);

    // Handshakes: a request transfers on a cycle with req_valid && req_ready
    // && !kill; a redirect transfers on a cycle with redir_valid && redir_ready.
    // redir_valid, once raised, stays up with redir_pc stable until it
    // transfers or the branch is killed/reset.

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  funct3_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] pc_q;
    logic [31:0] imm_q;
    logic [31:0] target;
    logic        cond;
    logic        load_req;
    logic        load_redir;
    logic        cnt_inc;

    branch_cond u_cond (
        .rs1    (rs1_q),
        .rs2    (rs2_q),
        .funct3 (funct3_q),
        .cond   (cond)
    );

    assign target    = pc_q + imm_q;
    assign dbg_state = state;

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        res_valid   = 1'b0;
        res_taken   = 1'b0;
        misalign    = 1'b0;
        redir_valid = 1'b0;
        flush       = 1'b0;
        load_req    = 1'b0;
        load_redir  = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !kill) begin
                    load_req  = 1'b1;
                    state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                state_nxt = ST_IDLE;
                if (!kill) begin
                    res_valid = 1'b1;
                    res_taken = cond;
                    if (cond) begin
                        if (target[1:0] != 2'b00) begin
                            misalign = 1'b1;
                        end else begin
                            load_redir = 1'b1;
                            state_nxt  = ST_REDIR;
                        end
                    end
                end
            end
            ST_REDIR: begin
                if (kill) begin
                    state_nxt = ST_IDLE;
                end else begin
                    redir_valid = 1'b1;
                    if (redir_ready) begin
                        flush     = 1'b1;
                        cnt_inc   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            funct3_q  <= 3'd0;
            rs1_q     <= 32'd0;
            rs2_q     <= 32'd0;
            pc_q      <= 32'd0;
            imm_q     <= 32'd0;
            redir_pc  <= 32'd0;
            taken_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load_req) begin
                funct3_q <= req_funct3;
                rs1_q    <= req_rs1;
                rs2_q    <= req_rs2;
                pc_q     <= req_pc;
                imm_q    <= req_imm;
            end
            if (load_redir) begin
                redir_pc <= target;
            end
            if (cnt_inc) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed vector table, hand-written
// reset/kill sequences, then randomized branches against a reference model.
module tb_branch_ctrl;
    import branch_ctrl_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1, req_rs2, req_pc, req_imm;
    logic        kill;
    logic        redir_ready;

    logic        req_ready, res_valid, res_taken, misalign, redir_valid, flush;
    logic [31:0] redir_pc;
    logic [15:0] taken_cnt;
    state_t      dbg_state;

    logic        s_req_ready, s_res_valid, s_res_taken, s_misalign, s_redir_valid, s_flush;
    logic [31:0] s_redir_pc;
    logic [2:0]  s_taken_cnt;
    state_t      s_dbg_state;

    always #5 clk = ~clk;

    branch_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_pc(req_pc), .req_imm(req_imm), .kill(kill),
        .res_valid(res_valid), .res_taken(res_taken), .misalign(misalign),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
        .flush(flush), .taken_cnt(taken_cnt), .dbg_state(dbg_state)
    );

    // Narrow-counter copy driven identically, so counter wrap is reachable quickly.
    branch_ctrl #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_pc(req_pc), .req_imm(req_imm), .kill(kill),
        .res_valid(s_res_valid), .res_taken(s_res_taken), .misalign(s_misalign),
        .redir_valid(s_redir_valid), .redir_pc(s_redir_pc), .redir_ready(redir_ready),
        .flush(s_flush), .taken_cnt(s_taken_cnt), .dbg_state(s_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_rdy, input logic e_rv,
                            input logic e_rt, input logic e_mis, input logic e_dv,
                            input logic e_fl);
        chk({tag, " req_ready"},   32'(req_ready),   32'(e_rdy));
        chk({tag, " res_valid"},   32'(res_valid),   32'(e_rv));
        chk({tag, " misalign"},    32'(misalign),    32'(e_mis));
        chk({tag, " redir_valid"}, 32'(redir_valid), 32'(e_dv));
        chk({tag, " flush"},       32'(flush),       32'(e_fl));
        chk({tag, " s_res_valid"}, 32'(s_res_valid), 32'(e_rv));
        chk({tag, " s_flush"},     32'(s_flush),     32'(e_fl));
        chk({tag, " s_req_ready"}, 32'(s_req_ready), 32'(e_rdy));
        chk({tag, " s_misalign"},  32'(s_misalign),  32'(e_mis));
        chk({tag, " s_redir_valid"}, 32'(s_redir_valid), 32'(e_dv));
        if (e_rv) begin
            chk({tag, " res_taken"},   32'(res_taken),   32'(e_rt));
            chk({tag, " s_res_taken"}, 32'(s_res_taken), 32'(e_rt));
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, " taken_cnt"},   32'(taken_cnt),   32'(exp_cnt % 65536));
        chk({tag, " s_taken_cnt"}, 32'(s_taken_cnt), 32'(exp_cnt % 8));
    endtask

    // Every accepted redirect must match the oldest expected target.
    always @(negedge clk) begin
        if (rst === 1'b0 && redir_valid === 1'b1 && redir_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor unexpected redirect: got 0x%08h expected none", redir_pc);
            end else begin
                chk("monitor redir_pc", redir_pc, exp_q.pop_front());
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic model_taken(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
        case (f3)
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return a == b;
        endcase
    endfunction

    // ---------------- driver ----------------
    // kill_at: -1 none, 0 in the resolve cycle, k>=1 in the k-th redirect cycle.
    task automatic run_branch(input string tag, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input int rdly, input int kill_at,
                              input logic e_taken, input logic e_mis);
        logic [31:0] tgt;
        logic        kl;
        logic        done;
        tgt = pc + imm;
        req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b;
        req_pc = pc; req_imm = imm; kill = 1'b0; redir_ready = 1'b0;
        @(negedge clk);
        chk_outs({tag, " idle"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        // Scramble request fields to show the operands were latched.
        req_valid = 1'b0; req_funct3 = 3'($urandom); req_rs1 = $urandom;
        req_rs2 = $urandom; req_pc = $urandom; req_imm = $urandom;
        kl = (kill_at == 0);
        kill = kl;
        @(negedge clk);
        chk_outs({tag, " eval"}, 1'b0, !kl, e_taken, !kl && e_taken && e_mis, 1'b0, 1'b0);
        @(posedge clk); #1;
        kill = 1'b0;
        done = kl || !e_taken || e_mis;
        for (int k = 1; k <= rdly + 1 && !done; k++) begin
            redir_ready = (k > rdly);
            kl = (kill_at == k);
            kill = kl;
            if (redir_ready && !kl) exp_q.push_back(tgt);
            @(negedge clk);
            chk_outs({tag, " redir"}, 1'b0, 1'b0, 1'b0, 1'b0, !kl, redir_ready && !kl);
            chk({tag, " redir_pc"}, redir_pc, tgt);
            chk({tag, " s_redir_pc"}, s_redir_pc, tgt);
            @(posedge clk); #1;
            if (!kl && redir_ready) exp_cnt++;
            done = kl || redir_ready;
            kill = 1'b0;
            redir_ready = 1'b0;
        end
        chk_cnt(tag);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a, b, pc, imm;
        int          rdly, kill_at;
        logic        e_taken, e_mis;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b, pc, imm;
        logic [31:0] tg;
        logic        t;
        int          rdly, kat;

        rst = 1'b1; req_valid = 1'b0; req_funct3 = 3'd0; req_rs1 = 32'd0;
        req_rs2 = 32'd0; req_pc = 32'd0; req_imm = 32'd0; kill = 1'b0;
        redir_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset redir_pc", redir_pc, 32'd0);
        chk("reset state", 32'(dbg_state), 32'(ST_IDLE));
        chk_cnt("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- directed vector table ----
        vecs = '{
            '{"beq_basic",   3'b000, 32'd5,        32'd5,        32'h100,      32'h20,       0, -1, 1'b1, 1'b0},
            '{"blt_neg",     3'b100, 32'hFFFFFFFF, 32'd1,        32'h200,      32'h40,       0, -1, 1'b1, 1'b0},
            '{"bltu_neg",    3'b110, 32'hFFFFFFFF, 32'd1,        32'h200,      32'h40,       0, -1, 1'b0, 1'b0},
            '{"bne_misal",   3'b001, 32'd1,        32'd2,        32'h100,      32'h2,        0, -1, 1'b1, 1'b1},
            '{"bge_stall",   3'b101, 32'd7,        32'd3,        32'h300,      32'hFFFFFFF0, 3, -1, 1'b1, 1'b0},
            '{"kill_redir",  3'b000, 32'd9,        32'd9,        32'h400,      32'h8,        5,  2, 1'b1, 1'b0},
            '{"beq_wrap",    3'b000, 32'd3,        32'd3,        32'hFFFFFFF0, 32'h20,       0, -1, 1'b1, 1'b0},
            '{"bgeu_small",  3'b111, 32'd1,        32'hFFFFFFFF, 32'h0,        32'h4,        0, -1, 1'b0, 1'b0},
            '{"f3_010_eq",   3'b010, 32'd4,        32'd4,        32'h0,        32'h4,        1, -1, 1'b1, 1'b0},
            '{"f3_011_ne",   3'b011, 32'd4,        32'd5,        32'h0,        32'h4,        0, -1, 1'b0, 1'b0},
            '{"kill_eval",   3'b000, 32'd1,        32'd1,        32'h10,       32'h10,       0,  0, 1'b1, 1'b0},
            '{"bge_eq_neg",  3'b101, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'h80,       32'h80,       0, -1, 1'b1, 1'b0},
            '{"blt_minmax",  3'b100, 32'h80000000, 32'h7FFFFFFF, 32'h1000,     32'hFFFFF000, 2, -1, 1'b1, 1'b0},
            '{"bgeu_misal",  3'b111, 32'd8,        32'd8,        32'h100,      32'h3,        0, -1, 1'b1, 1'b1}
        };
        foreach (vecs[i])
            run_branch(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].pc,
                       vecs[i].imm, vecs[i].rdly, vecs[i].kill_at,
                       vecs[i].e_taken, vecs[i].e_mis);
        // The wrapped target must have reached fetch as 0x10.
        chk("beq_wrap target", 32'hFFFFFFF0 + 32'h20, 32'h10);

        // ---- kill in IDLE blocks acceptance ----
        req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'd1; req_rs2 = 32'd1;
        req_pc = 32'h40; req_imm = 32'h4; kill = 1'b1;
        @(negedge clk);
        chk_outs("kill_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0; kill = 1'b0;
        @(negedge clk);
        chk_outs("kill_idle next", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;

        // ---- reset while waiting in REDIR ----
        req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'd5; req_rs2 = 32'd5;
        req_pc = 32'h500; req_imm = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_outs("rst_redir wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_redir pc", redir_pc, 32'h510);
        @(posedge clk); #1;
        rst = 1'b1; kill = 1'b1; redir_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; kill = 1'b0; redir_ready = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        chk_outs("rst_redir after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_redir redir_pc", redir_pc, 32'd0);
        chk_cnt("rst_redir");
        @(posedge clk); #1;

        // ---- randomized branches against the model ----
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b100; 3: f3 = 3'b101;
                4: f3 = 3'b110; 5: f3 = 3'b111; 6: f3 = 3'b010; default: f3 = 3'b011;
            endcase
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (32'd1 << $urandom_range(0, 31));
                default: b = $urandom;
            endcase
            pc  = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
            imm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31))
                                              : {{20{1'b0}}, 10'($urandom), 2'b00};
            if ($urandom_range(0, 1) == 1) imm = -imm;
            rdly = $urandom_range(0, 3);
            kat  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, rdly + 1) : -1;
            t  = model_taken(f3, a, b);
            tg = pc + imm;
            run_branch("rand", f3, a, b, pc, imm, rdly, kat, t, tg[1:0] != 2'b00);
        end

        repeat (2) @(posedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
